ycbcr2rgb_post: RTL and testbench

- Downstream stage of the Y-channel histogram-equalisation top.
- Consumes the equalised YCbCr stream: equalised Y, with Cb/Cr already delay-matched to Y.
- Converts it back to 8-bit RGB for display or VGA output.
- Fully pipelined BT.601 full-range (JPEG) inverse transform: 3-cycle fixed latency, sync signals delay-matched, output clamped to 0..255.

---
 rtl/vip_color_pkg.sv | 30 +++
 rtl/sat_u8.sv | 21 ++
 rtl/ycbcr2rgb_post.sv | 132 +++++++++++++
 tb/tb_ycbcr2rgb_post.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/vip_color_pkg.sv
// Shared constants and types for the YCbCr -> RGB colour pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vip_color_pkg;

    // Q8 inverse-transform coefficients (BT.601 full range)
    localparam int C_RCR = 359;   // 1.402
    localparam int C_GCB = 88;    // 0.344136
    localparam int C_GCR = 183;   // 0.714136
    localparam int C_BCB = 454;   // 1.772

    localparam int OFFSET_128 = 128;  // chroma offset-binary zero
    localparam int ROUND_Q8   = 128;  // half LSB before the >>8
    localparam int PIPE_LAT   = 3;    // input-to-output latency in clk

    localparam int ACC_W = 20;

    // Signed accumulator wide enough for Y<<8 plus all products
    typedef logic signed [ACC_W-1:0] acc_t;

    // Chroma after offset removal, -128..127
    typedef logic signed [8:0] chroma_t;

    // Sync signals travelling alongside the pixel data
    typedef struct packed {
        logic vsync;
        logic href;
    } sync_t;

endpackage

// File: rtl/sat_u8.sv
// Clamp a signed accumulator value to an unsigned 8-bit pixel.
// Latency: combinational.
// Backpressure: none.
module sat_u8
    import vip_color_pkg::*;
(
    input  acc_t       din,
    output logic [7:0] dout
);

    // Negative -> 0, above 255 -> 255, otherwise pass the low byte
    always_comb begin
        dout = din[7:0];
        if (din < 0) begin
            dout = 8'd0;
        end else if (din > 255) begin
            dout = 8'd255;
        end
    end

endmodule

// File: rtl/ycbcr2rgb_post.sv
// Full-range BT.601 YCbCr -> 8-bit RGB, with sync delay-matched to data.
// Latency: 3 clk fixed from per_img_* to post_img_*.
// Backpressure: none; accepts one pixel every clk and runs freely.
module ycbcr2rgb_post
    import vip_color_pkg::*;
#(
    parameter bit BLANK_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_img_vsync,
    input  logic       per_img_href,
    input  logic [7:0] per_img_y,
    input  logic [7:0] per_img_cb,
    input  logic [7:0] per_img_cr,
    output logic       post_img_vsync,
    output logic       post_img_href,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue
);

    localparam acc_t    RND    = acc_t'(ROUND_Q8);
    localparam chroma_t OFS    = chroma_t'(OFFSET_128);

    // Stage 1: luma scaled to Q8, chroma re-centred on zero
    acc_t    ys_s1_d, ys_s1_q;
    chroma_t cb_o_d, cb_o_q;
    chroma_t cr_o_d, cr_o_q;
    sync_t   sync_s1_d, sync_s1_q;

    // Stage 2: coefficient products
    acc_t    ys_s2_d, ys_s2_q;
    acc_t    p_rcr_d, p_rcr_q;
    acc_t    p_gcb_d, p_gcb_q;
    acc_t    p_gcr_d, p_gcr_q;
    acc_t    p_bcb_d, p_bcb_q;
    sync_t   sync_s2_d, sync_s2_q;

    // Stage 3: rounded sums, shifted back to integer, clamped
    acc_t       s_r, s_g, s_b;
    acc_t       sh_r, sh_g, sh_b;
    logic [7:0] sat_r, sat_g, sat_b;
    logic [7:0] red_d, red_q;
    logic [7:0] green_d, green_q;
    logic [7:0] blue_d, blue_q;
    sync_t      sync_s3_d, sync_s3_q;
    logic       blank;

    // Stage 1 next-state: Y<<8 and chroma offset removal
    always_comb begin
        ys_s1_d   = acc_t'({per_img_y, 8'b0});
        cb_o_d    = chroma_t'({1'b0, per_img_cb}) - OFS;
        cr_o_d    = chroma_t'({1'b0, per_img_cr}) - OFS;
        sync_s1_d = '{vsync: per_img_vsync, href: per_img_href};
    end

    // Stage 2 next-state: the four Q8 products, luma and sync carried along
    always_comb begin
        ys_s2_d   = ys_s1_q;
        p_rcr_d   = acc_t'(C_RCR * cr_o_q);
        p_gcb_d   = acc_t'(C_GCB * cb_o_q);
        p_gcr_d   = acc_t'(C_GCR * cr_o_q);
        p_bcb_d   = acc_t'(C_BCB * cb_o_q);
        sync_s2_d = sync_s1_q;
    end

    // Stage 3 arithmetic: rounded sums then arithmetic shift back by 8
    always_comb begin
        s_r  = ys_s2_q + p_rcr_q + RND;
        s_g  = ys_s2_q - p_gcb_q - p_gcr_q + RND;
        s_b  = ys_s2_q + p_bcb_q + RND;
        sh_r = s_r >>> 8;
        sh_g = s_g >>> 8;
        sh_b = s_b >>> 8;
    end

    sat_u8 u_sat_r (.din(sh_r), .dout(sat_r));
    sat_u8 u_sat_g (.din(sh_g), .dout(sat_g));
    sat_u8 u_sat_b (.din(sh_b), .dout(sat_b));

    // Stage 3 next-state: optional blanking outside the active line
    always_comb begin
        blank     = BLANK_ZERO && !sync_s2_q.href;
        red_d     = blank ? 8'd0 : sat_r;
        green_d   = blank ? 8'd0 : sat_g;
        blue_d    = blank ? 8'd0 : sat_b;
        sync_s3_d = sync_s2_q;
    end

    // Pipeline registers; reset flushes every stage immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ys_s1_q   <= '0;
            cb_o_q    <= '0;
            cr_o_q    <= '0;
            sync_s1_q <= '0;
            ys_s2_q   <= '0;
            p_rcr_q   <= '0;
            p_gcb_q   <= '0;
            p_gcr_q   <= '0;
            p_bcb_q   <= '0;
            sync_s2_q <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            sync_s3_q <= '0;
        end else begin
            ys_s1_q   <= ys_s1_d;
            cb_o_q    <= cb_o_d;
            cr_o_q    <= cr_o_d;
            sync_s1_q <= sync_s1_d;
            ys_s2_q   <= ys_s2_d;
            p_rcr_q   <= p_rcr_d;
            p_gcb_q   <= p_gcb_d;
            p_gcr_q   <= p_gcr_d;
            p_bcb_q   <= p_bcb_d;
            sync_s2_q <= sync_s2_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            sync_s3_q <= sync_s3_d;
        end
    end

    assign post_img_vsync = sync_s3_q.vsync;
    assign post_img_href  = sync_s3_q.href;
    assign post_img_red   = red_q;
    assign post_img_green = green_q;
    assign post_img_blue  = blue_q;

endmodule

// File: tb/tb_ycbcr2rgb_post.sv
// Scoreboard bench for ycbcr2rgb_post, blanking and pass-through variants side by side.
// Latency: expects each pixel 3 clk after it is applied.
// Backpressure: none; one pixel driven every clk.
module tb_ycbcr2rgb_post;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vs_i = 1'b0, hr_i = 1'b0;
    logic [7:0] y_i = '0, cb_i = '0, cr_i = '0;

    logic       vs_o, hr_o, vs_o0, hr_o0;
    logic [7:0] r_o, g_o, b_o, r_o0, g_o0, b_o0;

    int n_vec = 0;
    int n_err = 0;
    bit rel_pend = 1'b0;

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic [7:0] r, g, b;     // blanking instance
        logic [7:0] r0, g0, b0;  // pass-through instance
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    ycbcr2rgb_post #(.BLANK_ZERO(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vs_i), .per_img_href(hr_i),
        .per_img_y(y_i), .per_img_cb(cb_i), .per_img_cr(cr_i),
        .post_img_vsync(vs_o), .post_img_href(hr_o),
        .post_img_red(r_o), .post_img_green(g_o), .post_img_blue(b_o)
    );

    ycbcr2rgb_post #(.BLANK_ZERO(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vs_i), .per_img_href(hr_i),
        .per_img_y(y_i), .per_img_cb(cb_i), .per_img_cr(cr_i),
        .post_img_vsync(vs_o0), .post_img_href(hr_o0),
        .post_img_red(r_o0), .post_img_green(g_o0), .post_img_blue(b_o0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] clamp8(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // Reference transform straight from the Q8 equations
    function automatic exp_t model(input logic vs, input logic hr,
                                   input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        exp_t e;
        int ys, bo, co;
        ys = int'(y) * 256;
        bo = int'(cb) - 128;
        co = int'(cr) - 128;
        e.vs = vs;
        e.hr = hr;
        e.r0 = clamp8((ys + 359 * co + 128) >>> 8);
        e.g0 = clamp8((ys - 88 * bo - 183 * co + 128) >>> 8);
        e.b0 = clamp8((ys + 454 * bo + 128) >>> 8);
        e.r  = hr ? e.r0 : 8'd0;
        e.g  = hr ? e.g0 : 8'd0;
        e.b  = hr ? e.b0 : 8'd0;
        return e;
    endfunction

    // One pixel clock: check the output due now, then drive the next pixel
    task automatic cycle(input logic vs, input logic hr,
                         input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        exp_t e;
        @(negedge clk);
        e = '0;
        if (exp_q.size() == 3) e = exp_q.pop_front();
        chk("blank", {6'd0, vs_o, hr_o, r_o, g_o, b_o}, {6'd0, e.vs, e.hr, e.r, e.g, e.b});
        chk("pass",  {6'd0, vs_o0, hr_o0, r_o0, g_o0, b_o0}, {6'd0, e.vs, e.hr, e.r0, e.g0, e.b0});
        if (rel_pend) begin
            rst_n = 1'b1;
            rel_pend = 1'b0;
        end
        vs_i = vs; hr_i = hr; y_i = y; cb_i = cb; cr_i = cr;
        if (rst_n) exp_q.push_back(model(vs, hr, y, cb, cr));
    endtask

    // Asynchronous reset in the middle of a stream
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_blank", {6'd0, vs_o, hr_o, r_o, g_o, b_o}, 32'd0);
        chk("rst_async_pass",  {6'd0, vs_o0, hr_o0, r_o0, g_o0, b_o0}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        rel_pend = 1'b1;
    endtask

    initial begin
        // Held in reset: outputs must read zero
        cycle(1'b1, 1'b1, 8'd99, 8'd10, 8'd20);
        cycle(1'b1, 1'b1, 8'd99, 8'd10, 8'd20);
        rel_pend = 1'b1;

        // Directed pixels: mid-grey, saturations, clamp, blanking
        cycle(1'b1, 1'b0, 8'd0,   8'd128, 8'd128);
        cycle(1'b0, 1'b1, 8'd128, 8'd128, 8'd128);
        cycle(1'b0, 1'b1, 8'd255, 8'd128, 8'd255);
        cycle(1'b0, 1'b1, 8'd0,   8'd0,   8'd0);
        cycle(1'b0, 1'b1, 8'd76,  8'd85,  8'd255);
        cycle(1'b0, 1'b0, 8'd200, 8'd128, 8'd128);
        cycle(1'b0, 1'b1, 8'd255, 8'd255, 8'd0);
        cycle(1'b0, 1'b1, 8'd0,   8'd255, 8'd255);
        cycle(1'b1, 1'b0, 8'd200, 8'd128, 8'd128);

        // Random pixels with random sync
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom), 8'($urandom));
        end

        // Ramp with href high, interrupted by a reset
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'(40 + i * 12), 8'(i * 7), 8'(255 - i * 9));
        end
        mid_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 8'(60 + i * 15), 8'(200 - i * 5), 8'(i * 11));
        end

        // Drain the pipeline
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 8'd0, 8'd128, 8'd128);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
